// File: rtl/qeciphy_link_sequencer.sv
// Link bring-up sequencer: enables TX, then RX, and declares link up when both are ready.
// Failures retry through a back-off window until the retry budget is spent, then fault sticks.
module qeciphy_link_sequencer #(
  parameter int TRAIN_TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRIES          = 3,
  parameter int BACKOFF_CYCLES       = 256,
  localparam int RCW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           enable_i,
  input  logic           tx_rdy_i,
  input  logic           tx_fault_fatal_i,
  input  logic [3:0]     tx_error_code_i,
  input  logic           rx_rdy_i,
  input  logic           rx_fault_fatal_i,
  input  logic [3:0]     rx_error_code_i,
  output logic           tx_enable_o,
  output logic           rx_enable_o,
  output logic           link_ready_o,
  output logic           link_fault_o,
  output logic [3:0]     error_code_o,
  output logic [RCW-1:0] retry_count_o
);

  localparam int TMAX = (TRAIN_TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TRAIN_TIMEOUT_CYCLES
                                                                 : BACKOFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]  TOUT_LAST = TW'(TRAIN_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  BOFF_LAST = TW'(BACKOFF_CYCLES - 1);
  localparam logic [RCW-1:0] RC_MAX    = RCW'(MAX_RETRIES);

  typedef enum logic [6:0] {
    S_RESET    = 7'b0000001,
    S_IDLE     = 7'b0000010,
    S_TX_START = 7'b0000100,
    S_RX_TRAIN = 7'b0001000,
    S_LINK_UP  = 7'b0010000,
    S_BACKOFF  = 7'b0100000,
    S_FAULT    = 7'b1000000
  } state_t;

  state_t         state, state_nxt;
  logic [TW-1:0]  timer, timer_nxt;
  logic [RCW-1:0] retry, retry_nxt;
  logic [3:0]     err, err_nxt;

  logic           both_rdy, fail_win, tout, rdy_loss, fail;
  logic [3:0]     fail_code;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_RESET;
      timer <= '0;
      retry <= '0;
      err   <= 4'h0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      retry <= retry_nxt;
      err   <= err_nxt;
    end
  end

  // Failure detection and code priority: TX fault > RX fault > timeout > ready loss.
  always_comb begin
    both_rdy  = tx_rdy_i && rx_rdy_i;
    fail_win  = (state == S_TX_START) || (state == S_RX_TRAIN) || (state == S_LINK_UP);
    tout      = ((state == S_TX_START) && (timer == TOUT_LAST) && !tx_rdy_i) ||
                ((state == S_RX_TRAIN) && (timer == TOUT_LAST) && !both_rdy);
    rdy_loss  = (state == S_LINK_UP) && !both_rdy;
    fail      = fail_win && (tx_fault_fatal_i || rx_fault_fatal_i || tout || rdy_loss);
    fail_code = 4'hD;
    if (tx_fault_fatal_i)      fail_code = tx_error_code_i;
    else if (rx_fault_fatal_i) fail_code = rx_error_code_i;
    else if (tout)             fail_code = 4'hE;
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    retry_nxt = retry;
    err_nxt   = err;

    case (state)
      S_RESET:    state_nxt = S_IDLE;
      S_IDLE:     if (enable_i) state_nxt = S_TX_START;
      S_TX_START: if (tx_rdy_i) state_nxt = S_RX_TRAIN;
      S_RX_TRAIN: if (both_rdy) state_nxt = S_LINK_UP;
      S_LINK_UP:  state_nxt = S_LINK_UP;
      S_BACKOFF:  if (timer == BOFF_LAST) state_nxt = S_TX_START;
      S_FAULT:    state_nxt = S_FAULT;
      default:    state_nxt = S_RESET;
    endcase

    if (fail) begin
      err_nxt = fail_code;
      if (retry < RC_MAX) begin
        state_nxt = S_BACKOFF;
        retry_nxt = retry + RCW'(1);
      end else begin
        state_nxt = S_FAULT;
      end
    end

    // Timer restarts on any state change and only runs in the timed states.
    if (state_nxt != state)
      timer_nxt = '0;
    else if ((state == S_TX_START) || (state == S_RX_TRAIN) || (state == S_BACKOFF))
      timer_nxt = timer + TW'(1);

    if (!enable_i) begin
      state_nxt = S_IDLE;
      timer_nxt = '0;
      retry_nxt = '0;
      err_nxt   = 4'h0;
    end
  end

  assign tx_enable_o   = (state == S_TX_START) || (state == S_RX_TRAIN) || (state == S_LINK_UP);
  assign rx_enable_o   = (state == S_RX_TRAIN) || (state == S_LINK_UP);
  assign link_ready_o  = (state == S_LINK_UP);
  assign link_fault_o  = (state == S_FAULT);
  assign error_code_o  = err;
  assign retry_count_o = retry;

endmodule

// File: tb/tb_qeciphy_link_sequencer.sv
// Directed bench for the link sequencer: expectations queued with each stimulus step, checked after the edge.
module tb_qeciphy_link_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, en_b;
  logic       tx_rdy, tx_f, rx_rdy, rx_f;
  logic [3:0] tx_c, rx_c;

  logic       a_tx, a_rx, a_up, a_flt;
  logic [3:0] a_err;
  logic [1:0] a_rc;
  logic       b_tx, b_rx, b_up, b_flt;
  logic [3:0] b_err;
  logic [0:0] b_rc;

  typedef struct packed {
    logic       tx, rx, up, flt;
    logic [3:0] err;
    logic [1:0] rc;
  } obs_t;

  typedef struct {
    string tag;
    bit    on_b;
    obs_t  v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  qeciphy_link_sequencer #(.TRAIN_TIMEOUT_CYCLES(16), .MAX_RETRIES(2), .BACKOFF_CYCLES(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(en),
    .tx_rdy_i(tx_rdy), .tx_fault_fatal_i(tx_f), .tx_error_code_i(tx_c),
    .rx_rdy_i(rx_rdy), .rx_fault_fatal_i(rx_f), .rx_error_code_i(rx_c),
    .tx_enable_o(a_tx), .rx_enable_o(a_rx), .link_ready_o(a_up), .link_fault_o(a_flt),
    .error_code_o(a_err), .retry_count_o(a_rc));

  qeciphy_link_sequencer #(.TRAIN_TIMEOUT_CYCLES(16), .MAX_RETRIES(0), .BACKOFF_CYCLES(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en_b),
    .tx_rdy_i(tx_rdy), .tx_fault_fatal_i(tx_f), .tx_error_code_i(tx_c),
    .rx_rdy_i(rx_rdy), .rx_fault_fatal_i(rx_f), .rx_error_code_i(rx_c),
    .tx_enable_o(b_tx), .rx_enable_o(b_rx), .link_ready_o(b_up), .link_fault_o(b_flt),
    .error_code_o(b_err), .retry_count_o(b_rc));

  function automatic obs_t mk(logic tx, logic rx, logic up, logic flt, logic [3:0] err, logic [1:0] rc);
    obs_t o;
    o.tx = tx; o.rx = rx; o.up = up; o.flt = flt; o.err = err; o.rc = rc;
    return o;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    exp_t e;
    obs_t got;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = e.on_b ? mk(b_tx, b_rx, b_up, b_flt, b_err, {1'b0, b_rc})
                   : mk(a_tx, a_rx, a_up, a_flt, a_err, a_rc);
      checks++;
      assert (got === e.v) else begin
        errors++;
        $error("FAIL %s: got tx/rx/up/flt/err/rc=%b%b%b%b/%h/%0d expected %b%b%b%b/%h/%0d",
               e.tag, got.tx, got.rx, got.up, got.flt, got.err, got.rc,
               e.v.tx, e.v.rx, e.v.up, e.v.flt, e.v.err, e.v.rc);
      end
    end
  endtask

  // Queue the expected post-edge outputs for the stimulus just driven, advance one clock, compare.
  task automatic step(input string tag, input bit on_b, input obs_t v);
    exp_t e;
    e.tag = tag; e.on_b = on_b; e.v = v;
    exp_q.push_back(e);
    tick(1);
    drain();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en_b = 1'b0;
    tx_rdy = 1'b0; tx_f = 1'b0; rx_rdy = 1'b0; rx_f = 1'b0;
    tx_c = 4'h0; rx_c = 4'h0;
    tick(1);
    step("reset_a", 1'b0, mk(0,0,0,0,4'h0,0));
    step("reset_b", 1'b1, mk(0,0,0,0,4'h0,0));
    rst = 1'b0;
    step("idle", 1'b0, mk(0,0,0,0,4'h0,0));

    // Clean bring-up
    en = 1'b1;
    step("enable_tx", 1'b0, mk(1,0,0,0,4'h0,0));
    tick(1);
    tx_rdy = 1'b1;
    step("tx_rdy_rx_en", 1'b0, mk(1,1,0,0,4'h0,0));
    tick(3);
    rx_rdy = 1'b1;
    step("link_up", 1'b0, mk(1,1,1,0,4'h0,0));

    // RX fault in LINK_UP, then re-bring-up keeps the code
    rx_f = 1'b1; rx_c = 4'h2;
    step("rx_fault_backoff", 1'b0, mk(0,0,0,0,4'h2,1));
    rx_f = 1'b0;
    tick(3);
    step("backoff_to_tx", 1'b0, mk(1,0,0,0,4'h2,1));
    step("retry_rx", 1'b0, mk(1,1,0,0,4'h2,1));
    step("retry_up_keeps_err", 1'b0, mk(1,1,1,0,4'h2,1));

    // Ready loss without a fault
    rx_rdy = 1'b0;
    step("rdy_loss", 1'b0, mk(0,0,0,0,4'hD,2));
    rx_rdy = 1'b1;
    tick(3);
    step("rdy_loss_tx", 1'b0, mk(1,0,0,0,4'hD,2));
    step("rdy_loss_rx", 1'b0, mk(1,1,0,0,4'hD,2));
    step("rdy_loss_up", 1'b0, mk(1,1,1,0,4'hD,2));

    // Disable clears everything, then simultaneous faults in RX_TRAIN
    en = 1'b0; tx_rdy = 1'b0; rx_rdy = 1'b0;
    step("disable_clear", 1'b0, mk(0,0,0,0,4'h0,0));
    en = 1'b1;
    step("reenable_tx", 1'b0, mk(1,0,0,0,4'h0,0));
    tx_rdy = 1'b1;
    step("rx_train", 1'b0, mk(1,1,0,0,4'h0,0));
    tx_f = 1'b1; tx_c = 4'h3; rx_f = 1'b1; rx_c = 4'h2;
    step("dual_fault_tx_wins", 1'b0, mk(0,0,0,0,4'h3,1));
    tx_f = 1'b0; rx_f = 1'b0; tx_rdy = 1'b0;

    // Training timeouts exhaust the budget
    tick(3);
    step("bo_to_tx1", 1'b0, mk(1,0,0,0,4'h3,1));
    tick(14);
    step("pre_timeout1", 1'b0, mk(1,0,0,0,4'h3,1));
    step("timeout1", 1'b0, mk(0,0,0,0,4'hE,2));
    tick(3);
    step("bo_to_tx2", 1'b0, mk(1,0,0,0,4'hE,2));
    tick(14);
    step("pre_timeout2", 1'b0, mk(1,0,0,0,4'hE,2));
    step("timeout_fault", 1'b0, mk(0,0,0,1,4'hE,2));
    rx_f = 1'b1; rx_c = 4'h9;
    step("fault_sticky", 1'b0, mk(0,0,0,1,4'hE,2));
    rx_f = 1'b0;

    // Leave FAULT by disabling for one cycle
    en = 1'b0;
    step("fault_disable", 1'b0, mk(0,0,0,0,4'h0,0));
    en = 1'b1;
    step("fault_reenable", 1'b0, mk(1,0,0,0,4'h0,0));

    // Reset in the middle of BACKOFF
    tx_f = 1'b1; tx_c = 4'h5;
    step("tx_fault_backoff", 1'b0, mk(0,0,0,0,4'h5,1));
    tx_f = 1'b0;
    rst = 1'b1;
    step("rst_in_backoff", 1'b0, mk(0,0,0,0,4'h0,0));
    rst = 1'b0;
    step("rst_to_idle", 1'b0, mk(0,0,0,0,4'h0,0));
    step("idle_to_tx", 1'b0, mk(1,0,0,0,4'h0,0));

    // No retry budget: first failure is fatal
    en_b = 1'b1;
    step("b_enable", 1'b1, mk(1,0,0,0,4'h0,0));
    tx_f = 1'b1; tx_c = 4'h7;
    step("b_direct_fault", 1'b1, mk(0,0,0,1,4'h7,0));
    tx_f = 1'b0;
    step("b_fault_sticky", 1'b1, mk(0,0,0,1,4'h7,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
